mem_access_unit: RTL and testbench

Initiator-side memory access unit for the multi-cycle CPU. It sits between the datapath's load/store control and the word-wide unified memory, which has a combinational read, a synchronous word write and is indexed by `addr[7:2]`. The unit turns byte, halfword and word loads/stores into sequences of whole-word memory cycles. Sub-word stores use read-modify-write; loads get lane extraction with sign or zero extension.

---
 rtl/mem_access_unit.sv | 84 ++++++++
 tb/tb_mem_access_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word loads and stores into whole-word memory cycles
// Ports: clk, clrn (async active-low reset); req/wr/size/sext/addr/wdata request inputs;
//   busy/done/err status; rdata extended load result; m_addr/m_datain/m_we/m_dataout memory side.
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_datain,
  output logic          m_we,
  input  logic [31:0]   m_dataout
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t        state_q;
  logic          wr_q, sext_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q, datain_q;
  logic          bad;
  logic [4:0]    sh;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   msk, ld, mrg;
  // Lanes are big-endian, so the shift counts down from the top as the offset grows.
  always_comb begin
    bad = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    sh  = size_q == 2'b00 ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
    lb  = 8'(m_dataout >> sh);
    lh  = 16'(m_dataout >> sh);
    msk = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    ld  = size_q == 2'b00 ? {{24{sext_q & lb[7]}}, lb} :
          size_q == 2'b01 ? {{16{sext_q & lh[15]}}, lh} : m_dataout;
    mrg = (m_dataout & ~msk) | ((wdata_q << sh) & msk);
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      sext_q   <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      datain_q <= '0;
    end else
      case (state_q)
        IDLE: if (req) begin
          wr_q    <= wr;
          size_q  <= size;
          sext_q  <= sext;
          addr_q  <= addr;
          wdata_q <= wdata;
          err_q   <= bad;
          if (wr && size == 2'b10) datain_q <= wdata;
          state_q <= bad ? DONE : (wr && size == 2'b10) ? WR : RD;
        end
        RD: begin
          if (wr_q) datain_q <= mrg;
          else rdata_q <= ld;
          state_q <= wr_q ? WR : DONE;
        end
        WR:   state_q <= DONE;
        DONE: state_q <= IDLE;
      endcase
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign err      = done & err_q;
  assign m_we     = state_q == WR;
  assign m_addr   = {addr_q[AW-1:2], 2'b00};
  assign m_datain = datain_q;
  assign rdata    = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural word memory
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req = 1'b0, wr = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, m_we;
  logic [31:0] rdata, m_addr, m_datain, m_dataout;
  logic [31:0] mem [64];
  int          total = 0, bad = 0;
  int          lat, we_at, we_cnt;
  logic [31:0] we_d;
  logic        e, done_seen;

  mem_access_unit #(.AW(32)) dut (
    .clk(clk), .clrn(clrn), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .m_addr(m_addr), .m_datain(m_datain), .m_we(m_we), .m_dataout(m_dataout)
  );

  always #5 clk = ~clk;
  assign m_dataout = mem[m_addr[7:2]];
  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_datain;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until done (or a 10-cycle timeout, reported as lat=99).
  task automatic acc(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] wd, input logic hold);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    lat = 99; we_at = 0; we_cnt = 0; we_d = '0; e = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (m_we) begin we_cnt++; we_at = n; we_d = m_datain; end
      if (done) begin lat = n; e = err; break; end
    end
  endtask

  // Load and check result plus latency.
  task automatic ld(input string tag, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] exp);
    acc(1'b0, sz, sx, a, 32'h0, 1'b0);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rd"}, rdata, exp);
    chk({tag, "_err"}, {31'b0, e}, 0);
  endtask

  // Rejected access: done+err one cycle after accept, no write, rdata held.
  task automatic rej(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] held);
    acc(w, sz, 1'b1, a, 32'hDEAD_BEEF, 1'b0);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, {31'b0, e}, 1);
    chk({tag, "_we"}, we_cnt, 0);
    chk({tag, "_rd"}, rdata, held);
  endtask

  // Start a store, wait until the unit is in the given cycle after accept, then reset.
  task automatic mid_rst(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int at, input logic exp_we,
                         input logic [5:0] idx, input logic [31:0] exp_mem);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = sz; sext = 1'b0; addr = a; wdata = wd;
    @(posedge clk);
    done_seen = 1'b0;
    for (int n = 1; n <= at; n++) begin
      @(negedge clk);
      req = 1'b0;
      done_seen |= done;
    end
    chk({tag, "_busy_pre"}, {31'b0, busy}, 1);
    chk({tag, "_we_pre"}, {31'b0, m_we}, {31'b0, exp_we});
    clrn = 1'b0;
    #1;
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_we"}, {31'b0, m_we}, 0);
    @(negedge clk);
    clrn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      done_seen |= done;
    end
    chk({tag, "_nodone"}, {31'b0, done_seen}, 0);
    chk({tag, "_mem"}, mem[idx], exp_mem);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h20] = 32'h0000_00A3;
    mem[6'h21] = 32'h0000_0027;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_we", {31'b0, m_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mdin", m_datain, 0);
    clrn = 1'b1;

    ld("lb_s", 2'b00, 1'b1, 32'h83, 32'hFFFF_FFA3);
    ld("lb_z", 2'b00, 1'b0, 32'h83, 32'h0000_00A3);
    ld("lb_0", 2'b00, 1'b1, 32'h80, 32'h0000_0000);

    acc(1'b1, 2'b00, 1'b0, 32'h81, 32'h0000_005A, 1'b0);
    chk("sb_lat", lat, 3);
    chk("sb_weat", we_at, 2);
    chk("sb_wecnt", we_cnt, 1);
    chk("sb_din", we_d, 32'h005A_00A3);
    ld("sb_rb", 2'b10, 1'b0, 32'h80, 32'h005A_00A3);

    acc(1'b1, 2'b01, 1'b0, 32'h86, 32'h1234_BEEF, 1'b0);
    chk("sh_lat", lat, 3);
    chk("sh_mem", mem[6'h21], 32'h0000_BEEF);
    ld("lh_s", 2'b01, 1'b1, 32'h86, 32'hFFFF_BEEF);

    acc(1'b1, 2'b10, 1'b0, 32'h90, 32'h1234_5678, 1'b0);
    chk("sw_lat", lat, 2);
    chk("sw_weat", we_at, 1);
    chk("sw_din", we_d, 32'h1234_5678);
    ld("lw", 2'b10, 1'b0, 32'h90, 32'h1234_5678);

    acc(1'b1, 2'b10, 1'b0, 32'h94, 32'h8000_ABCD, 1'b0);
    ld("lh_hi", 2'b01, 1'b1, 32'h94, 32'hFFFF_8000);
    ld("lh_hiz", 2'b01, 1'b0, 32'h94, 32'h0000_8000);
    ld("lb_2", 2'b00, 1'b1, 32'h96, 32'hFFFF_FFAB);

    rej("e_w82", 1'b0, 2'b10, 32'h82, 32'hFFFF_FFAB);
    rej("e_h85", 1'b0, 2'b01, 32'h85, 32'hFFFF_FFAB);
    rej("e_sz3", 1'b0, 2'b11, 32'h80, 32'hFFFF_FFAB);
    rej("e_sw", 1'b1, 2'b10, 32'h91, 32'hFFFF_FFAB);
    chk("e_mem", mem[6'h24], 32'h1234_5678);

    // req held high through the whole access and the DONE edge
    acc(1'b1, 2'b00, 1'b0, 32'h9B, 32'h0000_0077, 1'b1);
    chk("hold_lat", lat, 3);
    chk("hold_wecnt", we_cnt, 1);
    @(negedge clk);
    chk("hold_idle", {31'b0, busy}, 0);
    req = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      done_seen |= done | m_we;
    end
    chk("hold_once", {31'b0, done_seen}, 0);
    chk("hold_mem", mem[6'h26], 32'h0000_0077);

    mid_rst("rst_rd", 2'b00, 32'h84, 32'h0000_0011, 1, 1'b0, 6'h21, 32'h0000_BEEF);
    chk("rst_rd_rdata", rdata, 0);
    mid_rst("rst_wr", 2'b10, 32'h84, 32'hCAFE_F00D, 1, 1'b1, 6'h21, 32'h0000_BEEF);
    ld("post_rst", 2'b10, 1'b0, 32'h84, 32'h0000_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
